// File: rtl/sha256_pkg.sv
// Shared SHA-256 types, round constants, initial hash value and bit functions.
// Latency: n/a (types, constants and pure functions only).
// Backpressure: n/a.
package sha256_pkg;

    typedef logic [31:0] word_t;
    // Word 7 is A (bits [255:224]) and word 0 is H, matching the {A..H} port packing.
    typedef word_t [7:0] state_t;

    typedef enum logic [1:0] {
        IDLE       = 2'd0,
        RUN        = 2'd1,
`ifdef SHA_DOUBLE_HASH_EN
        DONE       = 2'd2,
        PASS2_LOAD = 2'd3
`else
        DONE       = 2'd2
`endif
    } fsm_t;

    localparam state_t IV = {
        32'h6a09e667, 32'hbb67ae85, 32'h3c6ef372, 32'ha54ff53a,
        32'h510e527f, 32'h9b05688c, 32'h1f83d9ab, 32'h5be0cd19
    };

    localparam word_t K [64] = '{
        32'h428a2f98, 32'h71374491, 32'hb5c0fbcf, 32'he9b5dba5,
        32'h3956c25b, 32'h59f111f1, 32'h923f82a4, 32'hab1c5ed5,
        32'hd807aa98, 32'h12835b01, 32'h243185be, 32'h550c7dc3,
        32'h72be5d74, 32'h80deb1fe, 32'h9bdc06a7, 32'hc19bf174,
        32'he49b69c1, 32'hefbe4786, 32'h0fc19dc6, 32'h240ca1cc,
        32'h2de92c6f, 32'h4a7484aa, 32'h5cb0a9dc, 32'h76f988da,
        32'h983e5152, 32'ha831c66d, 32'hb00327c8, 32'hbf597fc7,
        32'hc6e00bf3, 32'hd5a79147, 32'h06ca6351, 32'h14292967,
        32'h27b70a85, 32'h2e1b2138, 32'h4d2c6dfc, 32'h53380d13,
        32'h650a7354, 32'h766a0abb, 32'h81c2c92e, 32'h92722c85,
        32'ha2bfe8a1, 32'ha81a664b, 32'hc24b8b70, 32'hc76c51a3,
        32'hd192e819, 32'hd6990624, 32'hf40e3585, 32'h106aa070,
        32'h19a4c116, 32'h1e376c08, 32'h2748774c, 32'h34b0bcb5,
        32'h391c0cb3, 32'h4ed8aa4a, 32'h5b9cca4f, 32'h682e6ff3,
        32'h748f82ee, 32'h78a5636f, 32'h84c87814, 32'h8cc70208,
        32'h90befffa, 32'ha4506ceb, 32'hbef9a3f7, 32'hc67178f2
    };

    function automatic word_t rotr(input word_t x, input int unsigned n);
        return (x >> n) | (x << (32 - n));
    endfunction

    function automatic word_t ch(input word_t e, input word_t f, input word_t g);
        return (e & f) ^ (~e & g);
    endfunction

    function automatic word_t maj(input word_t a, input word_t b, input word_t c);
        return (a & b) ^ (a & c) ^ (b & c);
    endfunction

    function automatic word_t big_sigma0(input word_t x);
        return rotr(x, 2) ^ rotr(x, 13) ^ rotr(x, 22);
    endfunction

    function automatic word_t big_sigma1(input word_t x);
        return rotr(x, 6) ^ rotr(x, 11) ^ rotr(x, 25);
    endfunction

    function automatic word_t small_sigma0(input word_t x);
        return rotr(x, 7) ^ rotr(x, 18) ^ (x >> 3);
    endfunction

    function automatic word_t small_sigma1(input word_t x);
        return rotr(x, 17) ^ rotr(x, 19) ^ (x >> 10);
    endfunction

endpackage

// File: rtl/sha256_round_comb.sv
// One combinational SHA-256 round: working state, K[t], W[t] -> next working state.
// Latency: 0 cycles (pure combinational).
// Backpressure: none; the engine decides when the result is registered.
module sha256_round_comb
    import sha256_pkg::*;
(
    input  state_t st_in,
    input  word_t  k,
    input  word_t  w,
    output state_t st_out
);

    word_t a, b, c, d, e, f, g, h;
    word_t t1, t2;

    // Unpack A..H, form T1/T2 and rotate the register file by one word.
    always_comb begin
        a = st_in[7];
        b = st_in[6];
        c = st_in[5];
        d = st_in[4];
        e = st_in[3];
        f = st_in[2];
        g = st_in[1];
        h = st_in[0];
        t1 = h + big_sigma1(e) + ch(e, f, g) + k + w;
        t2 = big_sigma0(a) + maj(a, b, c);
        st_out = {t1 + t2, a, b, c, d + t1, e, f, g};
    end

endmodule

// File: rtl/sha256_compress_iter.sv
// Iterative SHA-256 compression, ROUNDS_PER_CYCLE chained rounds per clock; SHA_DOUBLE_HASH_EN adds in_double.
// Latency: accept at edge N -> out_valid at edge N+64/R (N+2*(64/R)+1 for a double hash).
// Backpressure: in_ready only in IDLE; digest held in DONE until out_ready, no accept on the drain edge.
module sha256_compress_iter
    import sha256_pkg::*;
#(
    parameter int ROUNDS_PER_CYCLE = 1
)
(
    input  logic         clk,
    input  logic         rst,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [255:0] in_state,
    input  logic [511:0] in_block,
`ifdef SHA_DOUBLE_HASH_EN
    input  logic         in_double,
`endif
    output logic         out_valid,
    input  logic         out_ready,
    output logic [255:0] out_digest
);

    localparam int R = ROUNDS_PER_CYCLE;

    if (R != 1 && R != 2 && R != 4 && R != 8) begin : g_bad_rounds
        $error("ROUNDS_PER_CYCLE must be 1, 2, 4 or 8");
    end

    fsm_t          state_q, state_d;
    logic [6:0]    cnt_q, cnt_d;
    state_t        work_q, work_d;
    state_t        saved_q, saved_d;
    word_t [15:0]  win_q, win_d;      // win_q[0] is always W[cnt_q]
    logic [255:0]  dig_q, dig_d;
`ifdef SHA_DOUBLE_HASH_EN
    logic          dbl_q, dbl_d;
`endif

    state_t        round_out;
    word_t [15+R:0] ext;              // window extended by the R schedule words produced this cycle
    state_t        fin;               // feed-forward result of the current pass

    // Chain of R rounds; stage g handles round cnt_q+g with window word g.
    for (genvar g = 0; g < R; g++) begin : g_round
        state_t st_i;
        state_t st_o;
        word_t  k_w;
        if (g == 0) begin : g_first
            assign st_i = work_q;
        end else begin : g_next
            assign st_i = g_round[g-1].st_o;
        end
        assign k_w = K[cnt_q[5:0] + 6'(g)];
        sha256_round_comb u_round (
            .st_in  (st_i),
            .k      (k_w),
            .w      (win_q[g]),
            .st_out (st_o)
        );
    end

    assign round_out = g_round[R-1].st_o;

    // Message schedule expansion and feed-forward sum for the cycle in flight.
    always_comb begin
        ext = '0;
        fin = '0;
        for (int i = 0; i < 16; i++) begin
            ext[i] = win_q[i];
        end
        // Later words depend on earlier new ones (W[t-2]), so build in order.
        for (int j = 0; j < R; j++) begin
            ext[16+j] = small_sigma1(ext[14+j]) + ext[9+j] + small_sigma0(ext[1+j]) + ext[j];
        end
        for (int i = 0; i < 8; i++) begin
            fin[i] = saved_q[i] + round_out[i];
        end
    end

    // Next-state logic: accept, round sequencing, second-pass load, drain.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        work_d  = work_q;
        saved_d = saved_q;
        win_d   = win_q;
        dig_d   = dig_q;
`ifdef SHA_DOUBLE_HASH_EN
        dbl_d   = dbl_q;
`endif
        case (state_q)
            IDLE: begin
                // in_ready is high throughout IDLE, so in_valid alone is an accept.
                if (in_valid) begin
                    work_d  = in_state;
                    saved_d = in_state;
                    for (int i = 0; i < 16; i++) begin
                        win_d[i] = in_block[511 - 32*i -: 32];
                    end
                    cnt_d   = '0;
`ifdef SHA_DOUBLE_HASH_EN
                    dbl_d   = in_double;
`endif
                    state_d = RUN;
                end
            end
            RUN: begin
                work_d = round_out;
                for (int i = 0; i < 16; i++) begin
                    win_d[i] = ext[i + R];
                end
                cnt_d = cnt_q + 7'(R);
                if (cnt_q == 7'(64 - R)) begin
`ifdef SHA_DOUBLE_HASH_EN
                    if (dbl_q) begin
                        // Second pass hashes the 32-byte digest: one padded block, length 256 bits.
                        work_d  = IV;
                        saved_d = IV;
                        for (int i = 0; i < 8; i++) begin
                            win_d[i] = fin[7 - i];
                        end
                        win_d[8] = 32'h8000_0000;
                        for (int i = 9; i < 15; i++) begin
                            win_d[i] = '0;
                        end
                        win_d[15] = 32'h0000_0100;
                        state_d   = PASS2_LOAD;
                    end else begin
                        dig_d   = fin;
                        state_d = DONE;
                    end
`else
                    dig_d   = fin;
                    state_d = DONE;
`endif
                end
            end
`ifdef SHA_DOUBLE_HASH_EN
            PASS2_LOAD: begin
                cnt_d   = '0;
                dbl_d   = 1'b0;
                state_d = RUN;
            end
`endif
            DONE: begin
                if (out_ready) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State registers; reset aborts any job in flight.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            work_q  <= '0;
            saved_q <= '0;
            win_q   <= '0;
            dig_q   <= '0;
`ifdef SHA_DOUBLE_HASH_EN
            dbl_q   <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            work_q  <= work_d;
            saved_q <= saved_d;
            win_q   <= win_d;
            dig_q   <= dig_d;
`ifdef SHA_DOUBLE_HASH_EN
            dbl_q   <= dbl_d;
`endif
        end
    end

    assign in_ready   = (state_q == IDLE);
    assign out_valid  = (state_q == DONE);
    assign out_digest = dig_q;

endmodule

// File: tb/tb_sha256_compress_iter.sv
// Directed bench for sha256_compress_iter: known digests, latency, back-pressure, reset, back-to-back.
// Latency: main instance R=1, auxiliary instances R=2,4,8 share rst/inputs.
// Backpressure: exercised by holding out_ready low in DONE.
module tb_sha256_compress_iter;

    localparam logic [255:0] IV_S    = 256'h6a09e667_bb67ae85_3c6ef372_a54ff53a_510e527f_9b05688c_1f83d9ab_5be0cd19;
    localparam logic [255:0] ABC_D   = 256'hba7816bf_8f01cfea_414140de_5dae2223_b00361a3_96177a9c_b410ff61_f20015ad;
    localparam logic [255:0] EMPTY_D = 256'he3b0c442_98fc1c14_9afbf4c8_996fb924_27ae41e4_649b934c_a495991b_7852b855;
`ifdef SHA_DOUBLE_HASH_EN
    localparam logic [255:0] DBL_D   = 256'h5df6e0e2_761359d3_0a827505_8e299fcc_03815345_45f55cf4_3e41983f_5d4c9456;
`endif
    localparam logic [511:0] ABC_B   = {32'h61626380, 448'h0, 32'h00000018};
    localparam logic [511:0] EMPTY_B = {32'h80000000, 480'h0};

    logic         clk;
    logic         rst;
    logic         in_valid;
    logic         in_ready;
    logic [255:0] in_state;
    logic [511:0] in_block;
    logic         out_valid;
    logic         out_ready;
    logic [255:0] out_digest;
`ifdef SHA_DOUBLE_HASH_EN
    logic         in_double;
`endif

    logic         aux_in_valid;
    logic         aux_out_ready;
    logic [2:0]   aux_in_ready;
    logic [2:0]   aux_out_valid;
    logic [255:0] aux_dig [3];

    int checks = 0;
    int errors = 0;

    sha256_compress_iter #(.ROUNDS_PER_CYCLE(1)) dut (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_ready(in_ready),
        .in_state(in_state), .in_block(in_block),
`ifdef SHA_DOUBLE_HASH_EN
        .in_double(in_double),
`endif
        .out_valid(out_valid), .out_ready(out_ready), .out_digest(out_digest)
    );

    sha256_compress_iter #(.ROUNDS_PER_CYCLE(2)) dut_r2 (
        .clk(clk), .rst(rst),
        .in_valid(aux_in_valid), .in_ready(aux_in_ready[0]),
        .in_state(IV_S), .in_block(EMPTY_B),
`ifdef SHA_DOUBLE_HASH_EN
        .in_double(1'b0),
`endif
        .out_valid(aux_out_valid[0]), .out_ready(aux_out_ready), .out_digest(aux_dig[0])
    );

    sha256_compress_iter #(.ROUNDS_PER_CYCLE(4)) dut_r4 (
        .clk(clk), .rst(rst),
        .in_valid(aux_in_valid), .in_ready(aux_in_ready[1]),
        .in_state(IV_S), .in_block(EMPTY_B),
`ifdef SHA_DOUBLE_HASH_EN
        .in_double(1'b0),
`endif
        .out_valid(aux_out_valid[1]), .out_ready(aux_out_ready), .out_digest(aux_dig[1])
    );

    sha256_compress_iter #(.ROUNDS_PER_CYCLE(8)) dut_r8 (
        .clk(clk), .rst(rst),
        .in_valid(aux_in_valid), .in_ready(aux_in_ready[2]),
        .in_state(IV_S), .in_block(EMPTY_B),
`ifdef SHA_DOUBLE_HASH_EN
        .in_double(1'b0),
`endif
        .out_valid(aux_out_valid[2]), .out_ready(aux_out_ready), .out_digest(aux_dig[2])
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [255:0] got, input logic [255:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    // Advance to just after the next rising edge; all driving and sampling happens here.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Offer one job, then count edges from the accept edge until out_valid.
    task automatic run_job(input logic [255:0] st, input logic [511:0] blk,
                           input logic [255:0] exp_dig, input int exp_lat, input string tag);
        int lat;
        chk({tag, "_ready"}, 256'(in_ready), 256'(1));
        in_valid = 1'b1;
        in_state = st;
        in_block = blk;
        tick();
        in_valid = 1'b0;
        in_state = '0;
        in_block = '0;
        lat = 0;
        while (!out_valid && lat < 400) begin
            tick();
            lat++;
        end
        chk({tag, "_latency"}, 256'(lat), 256'(exp_lat));
        chk({tag, "_digest"}, out_digest, exp_dig);
        chk({tag, "_busy"}, 256'(in_ready), 256'(0));
    endtask

    task automatic drain(input string tag);
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        chk({tag, "_drain_valid"}, 256'(out_valid), 256'(0));
        chk({tag, "_drain_ready"}, 256'(in_ready), 256'(1));
    endtask

    initial begin
        int aux_lat [3];
        logic [255:0] aux_got [3];
        int acc_t [3];
        logic [255:0] b2b_dig [3];
        int n_acc;
        int n_dig;
        logic acc;

        rst = 1'b1;
        in_valid = 1'b0;
        in_state = '0;
        in_block = '0;
        out_ready = 1'b0;
        aux_in_valid = 1'b0;
        aux_out_ready = 1'b1;
`ifdef SHA_DOUBLE_HASH_EN
        in_double = 1'b0;
`endif
        tick();
        tick();
        chk("reset_in_ready", 256'(in_ready), 256'(1));
        chk("reset_out_valid", 256'(out_valid), 256'(0));
        chk("reset_digest", out_digest, 256'(0));
        rst = 1'b0;
        tick();

        // "abc" at R=1: 64 cycles.
        run_job(IV_S, ABC_B, ABC_D, 64, "abc");
        drain("abc");

        // Empty message on the R=2/4/8 instances: 32/16/8 cycles.
        for (int a = 0; a < 3; a++) begin
            aux_lat[a] = 0;
            aux_got[a] = '0;
            chk("aux_ready", 256'(aux_in_ready[a]), 256'(1));
        end
        aux_in_valid = 1'b1;
        tick();
        aux_in_valid = 1'b0;
        for (int c = 1; c <= 40; c++) begin
            tick();
            for (int a = 0; a < 3; a++) begin
                if (aux_out_valid[a] && aux_lat[a] == 0) begin
                    aux_lat[a] = c;
                    aux_got[a] = aux_dig[a];
                end
            end
        end
        chk("r2_latency", 256'(aux_lat[0]), 256'(32));
        chk("r4_latency", 256'(aux_lat[1]), 256'(16));
        chk("r8_latency", 256'(aux_lat[2]), 256'(8));
        chk("r2_digest", aux_got[0], EMPTY_D);
        chk("r4_digest", aux_got[1], EMPTY_D);
        chk("r8_digest", aux_got[2], EMPTY_D);

        // Back-pressure: digest held, in_valid pulses ignored for 20 cycles.
        run_job(IV_S, EMPTY_B, EMPTY_D, 64, "bp");
        in_state = IV_S;
        in_block = ABC_B;
        for (int c = 0; c < 20; c++) begin
            in_valid = c[0];
            tick();
            chk("bp_hold", {out_valid, in_ready, out_digest[253:0]}, {2'b10, EMPTY_D[253:0]});
        end
        in_valid = 1'b0;
        drain("bp");
        tick();
        chk("bp_no_accept", 256'(in_ready), 256'(1));

        // Reset during round 30 aborts the job at once.
        in_valid = 1'b1;
        in_state = IV_S;
        in_block = ABC_B;
        tick();
        in_valid = 1'b0;
        for (int c = 0; c < 30; c++) begin
            tick();
        end
        rst = 1'b1;
        #1;
        chk("midrst_out_valid", 256'(out_valid), 256'(0));
        chk("midrst_in_ready", 256'(in_ready), 256'(1));
        chk("midrst_digest", out_digest, 256'(0));
        #2;
        rst = 1'b0;
        tick();
        run_job(IV_S, ABC_B, ABC_D, 64, "after_rst");
        drain("after_rst");

        // Back-to-back: 64 RUN cycles, one DONE cycle (drain edge), one IDLE cycle -> accepts 66 edges apart.
        n_acc = 0;
        n_dig = 0;
        for (int i = 0; i < 3; i++) begin
            acc_t[i] = 0;
            b2b_dig[i] = '0;
        end
        in_valid = 1'b1;
        in_state = IV_S;
        in_block = EMPTY_B;
        out_ready = 1'b1;
        for (int c = 1; c <= 220; c++) begin
            acc = in_valid && in_ready;
            tick();
            if (acc && n_acc < 3) begin
                acc_t[n_acc] = c;
                n_acc++;
                if (n_acc == 3) in_valid = 1'b0;
            end
            if (out_valid && n_dig < 3) begin
                b2b_dig[n_dig] = out_digest;
                n_dig++;
            end
        end
        out_ready = 1'b0;
        chk("b2b_gap0", 256'(acc_t[1] - acc_t[0]), 256'(66));
        chk("b2b_gap1", 256'(acc_t[2] - acc_t[1]), 256'(66));
        for (int i = 0; i < 3; i++) begin
            chk("b2b_digest", b2b_dig[i], EMPTY_D);
        end

`ifdef SHA_DOUBLE_HASH_EN
        // SHA-256(SHA-256("")): 2*64+1 cycles.
        in_double = 1'b1;
        run_job(IV_S, EMPTY_B, DBL_D, 129, "double");
        in_double = 1'b0;
        drain("double");
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
